// File: rtl/i2c_master_param.sv
// Parameterised I2C master: START, address byte, DATA_BYTES write or read bytes, STOP.
// Optional macro I2C_NACK_ABORT_EN: a NACK in ADDR_ACK/WR_ACK jumps straight to STOP.
module i2c_master_param #(
    parameter int DATA_BYTES = 2,
    parameter int CLK_DIV    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    START_STB,
    input  logic                    RNW,
    input  logic [6:0]              I2C_ADDR,
    input  logic [8*DATA_BYTES-1:0] WR_DATA,
    input  logic                    SDA_IN,
    output logic                    SDA_OE,
    output logic                    SDA_OUT,
    output logic                    SCL,
    output logic [8*DATA_BYTES-1:0] RD_DATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    NACK
);
    localparam int W     = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(3 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_HI   = CNT_W'(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(3 * CLK_DIV - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(DATA_BYTES - 1);
`ifdef I2C_NACK_ABORT_EN
    localparam logic NACK_ABORT = 1'b1;
`else
    localparam logic NACK_ABORT = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [1:0]       byte_reg, byte_next;
    logic [7:0]       addr_shift_reg, addr_shift_next;
    logic [W-1:0]     wr_shift_reg, wr_shift_next;
    logic             rnw_reg, rnw_next;
    logic             slot_end, low_next, last_byte;

    logic             scl_reg, sda_oe_reg, sda_out_reg, busy_reg, done_reg, nack_reg;
    logic [W-1:0]     rd_data_reg;

    assign SCL     = scl_reg;
    assign SDA_OE  = sda_oe_reg;
    assign SDA_OUT = sda_out_reg;
    assign BUSY    = busy_reg;
    assign DONE    = done_reg;
    assign NACK    = nack_reg;
    assign RD_DATA = rd_data_reg;

    always_comb begin
        state_next      = state_reg;
        bit_next        = bit_reg;
        byte_next       = byte_reg;
        addr_shift_next = addr_shift_reg;
        wr_shift_next   = wr_shift_reg;
        rnw_next        = rnw_reg;
        slot_end        = (cnt_reg == SLOT_LAST);
        last_byte       = (byte_reg == BYTE_LAST);
        cnt_next        = slot_end ? '0 : cnt_reg + CNT_W'(1);
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (START_STB) begin
                    state_next      = START;
                    addr_shift_next = {I2C_ADDR, RNW};
                    wr_shift_next   = WR_DATA;
                    rnw_next        = RNW;
                end
            end
            START: if (slot_end) begin
                state_next = ADDR;
                bit_next   = '0;
            end
            ADDR: if (slot_end) begin
                addr_shift_next = {addr_shift_reg[6:0], 1'b0};
                bit_next        = bit_reg + 3'd1;
                if (bit_reg == 3'd7) state_next = ADDR_ACK;
            end
            ADDR_ACK: if (slot_end) begin
                byte_next = '0;
                if (NACK_ABORT && SDA_IN) state_next = STOP;
                else                      state_next = rnw_reg ? RD_BYTE : WR_BYTE;
            end
            WR_BYTE: if (slot_end) begin
                wr_shift_next = {wr_shift_reg[W-2:0], 1'b0};
                bit_next      = bit_reg + 3'd1;
                if (bit_reg == 3'd7) state_next = WR_ACK;
            end
            WR_ACK: if (slot_end) begin
                if ((NACK_ABORT && SDA_IN) || last_byte) state_next = STOP;
                else begin
                    state_next = WR_BYTE;
                    byte_next  = byte_reg + 2'd1;
                end
            end
            RD_BYTE: if (slot_end) begin
                bit_next = bit_reg + 3'd1;
                if (bit_reg == 3'd7) state_next = RD_ACK;
            end
            RD_ACK: if (slot_end) begin
                if (last_byte) state_next = STOP;
                else begin
                    state_next = RD_BYTE;
                    byte_next  = byte_reg + 2'd1;
                end
            end
            STOP: begin
                cnt_next = (cnt_reg == STOP_LAST) ? '0 : cnt_reg + CNT_W'(1);
                if (cnt_reg == STOP_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        low_next = (cnt_next < HALF);
    end

    // Bus outputs are registered from the upcoming state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            byte_reg       <= '0;
            addr_shift_reg <= '0;
            wr_shift_reg   <= '0;
            rnw_reg        <= 1'b0;
            scl_reg        <= 1'b1;
            sda_oe_reg     <= 1'b1;
            sda_out_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            nack_reg       <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            byte_reg       <= byte_next;
            addr_shift_reg <= addr_shift_next;
            wr_shift_reg   <= wr_shift_next;
            rnw_reg        <= rnw_next;
            busy_reg       <= (state_next != IDLE);
            done_reg       <= (state_reg == STOP) && (state_next == IDLE);
            if (state_reg == IDLE && START_STB)
                nack_reg <= 1'b0;
            else if ((state_reg == ADDR_ACK || state_reg == WR_ACK) && slot_end && SDA_IN)
                nack_reg <= 1'b1;
            if (state_reg == RD_BYTE && slot_end)
                rd_data_reg <= {rd_data_reg[W-2:0], SDA_IN};
            case (state_next)
                START: begin
                    scl_reg     <= 1'b1;
                    sda_oe_reg  <= 1'b1;
                    sda_out_reg <= 1'b0;
                end
                ADDR: begin
                    scl_reg     <= !low_next;
                    sda_oe_reg  <= 1'b1;
                    sda_out_reg <= addr_shift_next[7];
                end
                ADDR_ACK, WR_ACK, RD_BYTE: begin
                    scl_reg     <= !low_next;
                    sda_oe_reg  <= 1'b0;
                    sda_out_reg <= 1'b1;
                end
                WR_BYTE: begin
                    scl_reg     <= !low_next;
                    sda_oe_reg  <= 1'b1;
                    sda_out_reg <= wr_shift_next[W-1];
                end
                RD_ACK: begin
                    scl_reg     <= !low_next;
                    sda_oe_reg  <= 1'b1;
                    sda_out_reg <= (byte_next == BYTE_LAST);
                end
                STOP: begin
                    scl_reg     <= !low_next;
                    sda_oe_reg  <= 1'b1;
                    sda_out_reg <= (cnt_next >= STOP_HI);
                end
                default: begin
                    scl_reg     <= 1'b1;
                    sda_oe_reg  <= 1'b1;
                    sda_out_reg <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/i2c_master_param.md
I2C_MASTER_PARAM -- requirements
Module: i2c_master_param

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2: number of data bytes per transaction, legal range 1..4.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL half-period, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port START_STB  input  1  one-cycle transaction request.
REQ-006 SHALL have port RNW  input  1  1 = read, 0 = write; sampled with START_STB.
REQ-007 SHALL have port I2C_ADDR  input  7  target address; sampled with START_STB.
REQ-008 SHALL have port WR_DATA  input  8*DATA_BYTES  write payload; sampled with START_STB.
REQ-009 SHALL have port SDA_IN  input  1  SDA level seen from the bus.
REQ-010 SHALL have port SDA_OE  output  1  1 = master drives SDA_OUT; 0 = master samples SDA_IN.
REQ-011 SHALL have port SDA_OUT  output  1  SDA value driven by the master.
REQ-012 SHALL have port SCL  output  1  serial clock.
REQ-013 SHALL have port RD_DATA  output  8*DATA_BYTES  read payload.
REQ-014 SHALL have port BUSY  output  1  transaction in progress.
REQ-015 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-016 SHALL have port NACK  output  1  sticky flag: an ACK slot sampled SDA_IN=1.

Function
REQ-017 SHALL use states IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
REQ-018 SHALL, in IDLE, accept START_STB: latch {I2C_ADDR,RNW}, WR_DATA and RNW; clear NACK; BUSY=1 from the next cycle.
REQ-019 SHALL ignore START_STB while BUSY=1.
REQ-020 SHALL hold START for 2*CLK_DIV cycles: SCL=1 throughout; SDA_OUT=0 from the first cycle.
REQ-021 SHALL make each bit slot 2*CLK_DIV cycles: SCL=0 for CLK_DIV cycles, then SCL=1 for CLK_DIV cycles.
REQ-022 SHALL change SDA_OUT and SDA_OE only on the first cycle of a slot's SCL-low phase.
REQ-023 SHALL sample SDA_IN on the last cycle of the SCL-high phase.
REQ-024 SHALL send the address byte {I2C_ADDR,RNW} MSB first.
REQ-025 SHALL, in every master-to-slave ACK slot (ADDR_ACK, WR_ACK), set SDA_OE=0 and sample ACK as SDA_IN (0 = ACK).
REQ-026 SHALL, on write, send WR_DATA MSB first: byte DATA_BYTES-1 first, each byte followed by WR_ACK.
REQ-027 SHALL, on read, set SDA_OE=0 during RD_BYTE and shift SDA_IN into RD_DATA MSB first; the first received byte goes to the most significant byte.
REQ-028 SHALL, in RD_ACK, drive SDA_OE=1 with SDA_OUT=0 after every byte except the last, and SDA_OUT=1 (NACK) after the last.
REQ-029 SHALL hold STOP for 3*CLK_DIV cycles: SCL=0/SDA=0, then SCL=1/SDA=0, then SCL=1/SDA=1, each CLK_DIV cycles.
REQ-030 SHALL, after STOP, return to IDLE with BUSY=0 and DONE=1 for exactly one cycle.
REQ-031 SHALL take CLK_DIV*(23+18*DATA_BYTES) cycles for an unaborted transaction, from the first BUSY cycle to the last STOP cycle.
REQ-032 SHALL update RD_DATA only on read transactions; RD_DATA SHALL hold its value otherwise.
REQ-033 SHALL, in IDLE, drive SCL=1, SDA_OE=1, SDA_OUT=1.
REQ-034 SHALL set NACK when an ACK slot samples SDA_IN=1; NACK SHALL hold until the next accepted START_STB or reset.

Reset
REQ-035 SHALL, when rst=1 at a clock edge, enter IDLE regardless of state, including mid-transaction, aborting without issuing STOP.
REQ-036 SHALL give reset values SCL=1, SDA_OE=1, SDA_OUT=1, BUSY=0, DONE=0, NACK=0, RD_DATA=0, with the divider and bit counters cleared.
REQ-037 SHALL give rst priority over START_STB in the same cycle.

Configuration
REQ-038 SHALL, with I2C_NACK_ABORT_EN defined, go to STOP immediately after a NACK in ADDR_ACK or WR_ACK, skipping the remaining bytes, then pulse DONE.
REQ-039 SHALL, with I2C_NACK_ABORT_EN undefined, set NACK but complete all DATA_BYTES bytes normally.

Verification
REQ-040 SHALL cover write: CLK_DIV=4, DATA_BYTES=2, addr 0x2A, RNW=0, WR_DATA=0xBEEF, slave ACKs all -> SDA bytes 0x54, 0xBE, 0xEF; DONE 236 cycles after BUSY rises; NACK=0.
REQ-041 SHALL cover read: addr 0x2A, RNW=1, slave sends 0x12 then 0x34 -> RD_DATA=0x1234; master ACKs byte 1 and NACKs byte 2.
REQ-042 SHALL cover address NACK with I2C_NACK_ABORT_EN: SDA_IN=1 in ADDR_ACK -> NACK=1, STOP follows, DONE 92 cycles after BUSY rises; without the macro, DONE at 236 and NACK=1.
REQ-043 SHALL cover a START_STB pulse at cycle 50 of an active transaction -> ignored; latched data unchanged; exactly one DONE.
REQ-044 SHALL cover reset asserted mid-RD_BYTE -> next cycle SCL=1, SDA_OE=1, SDA_OUT=1, BUSY=0, RD_DATA=0, no DONE.
REQ-045 SHALL cover DATA_BYTES=4, CLK_DIV=2, write 0xDEADBEEF -> four data bytes on SDA in order DE, AD, BE, EF; DONE after 190 cycles.
